gain_div: RTL and testbench
===========================

// Module: gain_div
// PURPOSE
//  Inverse of the equalizer gain stage: recovers yk = ykgain / gain_set in signed Q(p.f).
//  Sequential restoring divider, one quotient bit per clock, start/done handshake.
//  Sits after a band's gain multiplier; used for gain calibration and readback of the
//  pre-gain sample.
//  Result truncates toward zero and saturates to the Width-bit range.
// PARAMETERS
//  p      4           integer bits of the Q format (excluding sign)
//  f      13          fractional bits of the Q format
//  Width  1+p+f (18)  total signed word width of all data ports
// PORTS
//  clk       in   1      system clock, rising edge
//  reset     in   1      asynchronous, active-high reset
//  start     in   1      request; honoured only in IDLE
//  ykgain    in   Width  signed dividend (gained sample), sampled on accepted start
//  gain_set  in   Width  signed divisor (gain), sampled on accepted start
//  yk        out  Width  signed quotient; holds last result until next done
//  busy      out  1      high from cycle after accepted start until done cycle (exclusive)
//  done      out  1      one-cycle pulse; yk/sat/div_zero valid from this cycle
//  sat       out  1      last result was saturated (clipped)
//  div_zero  out  1      last divisor was zero
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; yk=0, busy=0, done=0, sat=0, div_zero=0.
//  - Reset mid-operation aborts the operation. No done pulse is generated.
//  States: IDLE -> DIV -> FIX -> IDLE. N = Width+f iterations (31 with the defaults).
//  IDLE, cycle T, start=1:
//  - Latch sign = ykgain[MSB]^gain_set[MSB].
//  - Latch |ykgain| and |gain_set| as Width-bit unsigned values (|-2^(Width-1)| is representable).
//  - Latch zflag = (gain_set==0).
//  - Clear iteration counter. Go to DIV.
//  DIV, cycles T+1..T+N, busy=1:
//  - Dividend = |ykgain| << f (Width+f bits), processed MSB first.
//  - Each cycle: shift the next dividend bit into the partial remainder; trial-subtract |gain_set|.
//  - Quotient bit = no-borrow. Restore the remainder on borrow.
//  - Quotient register is Width+f bits.
//  FIX, cycle T+N+1, busy=1:
//  - If zflag: yk = 0 when ykgain==0, else the saturation limit of the latched sign;
//    sat=0, div_zero=1.
//  - Otherwise, for positive sign: if Q > 2^(Width-1)-1 then yk=2^(Width-1)-1 and sat=1,
//    else yk=Q.
//  - Otherwise, for negative sign: if Q > 2^(Width-1) then yk=-2^(Width-1) and sat=1,
//    else yk=-Q.
//  - Registered outputs update at the clock edge ending this cycle.
//  - Go to IDLE.
//  Cycle T+N+2: done=1, busy=0, new yk/sat/div_zero visible.
//  - Fixed latency start->done = N+2 (33) cycles, including the divide-by-zero case.
//  start during DIV/FIX: ignored. Input changes after acceptance: ignored.
//  start in the done cycle is accepted (FSM is already in IDLE). Back-to-back throughput is 1 per N+2.
//  done never asserts without a preceding accepted start.
//  Quotient truncates toward zero (magnitude truncation, sign applied afterwards).
// TESTING (defaults p=4, f=13; 1.0 = 18'h02000)
//  1. ykgain=18'h04000 (2.0), gain_set=18'h02000 (1.0), start at T
//     -> done at T+33, yk=18'h04000, sat=0, div_zero=0; busy high T+1..T+32.
//  2. ykgain=18'h03000 (1.5), gain_set=18'h06000 (3.0) -> yk=18'h01000 (0.5).
//     Then 18'h02000/18'h06000 -> yk=18'h00AAA (truncated 1/3).
//  3. ykgain=18'h3E000 (-1.0), gain_set=18'h04000 -> yk=18'h3F000 (-0.5).
//     Then ykgain=18'h3E000, gain_set=18'h06000 -> yk=18'h3F556 (-1/3 truncated toward zero).
//  4. ykgain=18'h1E000 (15.0), gain_set=18'h00800 (0.25) -> yk=18'h1FFFF, sat=1.
//     Then ykgain=18'h20000 (-16.0), gain_set=18'h02000 (1.0) -> yk=18'h20000, sat=0.
//  5. ykgain=18'h02000, gain_set=0 -> at T+33: yk=18'h1FFFF, div_zero=1, sat=0.
//     Then ykgain=0, gain_set=0 -> yk=0, div_zero=1.
//  6. start pulsed again at T+5 with other operands -> ignored, result of the first operands at T+33.
//     Then reset pulse at T+10 of a new op -> yk=0, busy=0, no done; next start works normally.

Source files
------------

// File: rtl/gain_div.sv
// Signed Q(p.f) divider: yk = ykgain / gain_set, restoring, one quotient bit per clock.
// Truncates toward zero, saturates to the Width-bit range, flags divide-by-zero.
module gain_div #(
    parameter int unsigned p     = 4,
    parameter int unsigned f     = 13,
    parameter int unsigned Width = 1 + p + f
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Width-1:0] ykgain,
    input  logic [Width-1:0] gain_set,
    output logic [Width-1:0] yk,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic             div_zero
);

    localparam int unsigned N  = Width + f;
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned RW = Width - 1;

    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [N-1:0]     QPOS = (N'(1) << (Width - 1)) - N'(1);
    localparam logic [N-1:0]     QNEG = N'(1) << (Width - 1);
    localparam logic [Width-1:0] YPOS = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] YNEG = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t          state;
    logic [N-1:0]    dvd;
    logic [Width-1:0] dsr;
    logic [RW-1:0]   rem;
    logic [N-1:0]    q;
    logic [CW-1:0]   cnt;
    logic            sign;
    logic            zflag;
    logic            azero;

    logic [Width-1:0] mag_a_c;
    logic [Width-1:0] mag_b_c;
    logic [Width-1:0] sh_c;
    logic [Width-1:0] diff_c;
    logic             nob_c;

    // Operand magnitudes; the most negative value maps to 2^(Width-1) unsigned.
    assign mag_a_c = ykgain[Width-1]   ? (-ykgain)   : ykgain;
    assign mag_b_c = gain_set[Width-1] ? (-gain_set) : gain_set;

    // Remainder stays below |gain_set| <= 2^(Width-1), so it fits Width-1 bits.
    assign sh_c   = {rem, dvd[N-1]};
    assign nob_c  = (sh_c >= dsr);
    assign diff_c = sh_c - dsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            yk       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 1'b0;
            div_zero <= 1'b0;
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            q        <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            zflag    <= 1'b0;
            azero    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= ykgain[Width-1] ^ gain_set[Width-1];
                        dvd   <= {mag_a_c, {f{1'b0}}};
                        dsr   <= mag_b_c;
                        zflag <= (gain_set == '0);
                        azero <= (ykgain == '0);
                        rem   <= '0;
                        q     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= DIV;
                    end
                end
                DIV: begin
                    dvd <= dvd << 1;
                    rem <= RW'(nob_c ? diff_c : sh_c);
                    q   <= {q[N-2:0], nob_c};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Sign application, saturation and divide-by-zero resolution.
                    if (zflag) begin
                        div_zero <= 1'b1;
                        sat      <= 1'b0;
                        yk       <= azero ? '0 : (sign ? YNEG : YPOS);
                    end else begin
                        div_zero <= 1'b0;
                        if (!sign) begin
                            if (q > QPOS) begin
                                yk  <= YPOS;
                                sat <= 1'b1;
                            end else begin
                                yk  <= q[Width-1:0];
                                sat <= 1'b0;
                            end
                        end else begin
                            if (q > QNEG) begin
                                yk  <= YNEG;
                                sat <= 1'b1;
                            end else begin
                                yk  <= -q[Width-1:0];
                                sat <= 1'b0;
                            end
                        end
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gain_div.sv
// Scoreboard bench for gain_div: directed cases plus randomized operands against an arithmetic model.
module tb_gain_div;

    localparam int unsigned W   = 18;
    localparam int unsigned F   = 13;
    localparam int unsigned LAT = 33;
    localparam longint      MAXP = 131071;
    localparam longint      MAXN = -131072;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] ykgain = '0;
    logic [W-1:0] gain_set = '0;
    logic [W-1:0] yk;
    logic         busy;
    logic         done;
    logic         sat;
    logic         div_zero;

    gain_div dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ykgain   (ykgain),
        .gain_set (gain_set),
        .yk       (yk),
        .busy     (busy),
        .done     (done),
        .sat      (sat),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] yk;
        logic         sat;
        logic         dz;
        logic [31:0]  due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] y, input logic s, input logic z);
        exp_t e;
        e = '0;
        e.yk = y;
        e.sat = s;
        e.dz = z;
        return e;
    endfunction

    // Reference: exact integer quotient of magnitudes, sign applied, then clamped.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, ma, mb, qv, val;
        bit     neg;
        e = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        neg = (sa < 0) != (sb < 0);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (sb == 0) begin
            e.dz = 1'b1;
            val = (sa == 0) ? 0 : (neg ? MAXN : MAXP);
        end else begin
            qv = (ma * (longint'(1) << F)) / mb;
            val = neg ? -qv : qv;
            if (val > MAXP) begin
                val = MAXP;
                e.sat = 1'b1;
            end else if (val < MAXN) begin
                val = MAXN;
                e.sat = 1'b1;
            end
        end
        e.yk = W'(val);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("yk", 32'(yk), 32'(mon_e.yk));
                check("sat", 32'(sat), 32'(mon_e.sat));
                check("div_zero", 32'(div_zero), 32'(mon_e.dz));
                check("latency", cyc, mon_e.due);
            end
        end
    end

    // Called at a negedge; start is sampled at the next rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        start = 1'b1;
        ykgain = a;
        gain_set = b;
        e.due = cyc + LAT;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        ykgain = W'($urandom);
        gain_set = W'($urandom);
    endtask

    task automatic wait_done(input bit chk_busy);
        int n = 0;
        while (!done && n < 40) begin
            if (chk_busy) check("busy_high", 32'(busy), 32'd1);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", LAT);
        end else if (chk_busy) begin
            check("busy_at_done", 32'(busy), 32'd0);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] sp [6];
        logic [W-1:0] v;
        sp = '{18'h00000, 18'h20000, 18'h1FFFF, 18'h3FFFF, 18'h00001, 18'h02000};
        case ($urandom_range(0, 3))
            0: v = sp[$urandom_range(0, 5)];
            1: begin
                v = W'($urandom_range(1, 4096));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        logic [W-1:0] a, b;
        repeat (3) @(negedge clk);
        check("rst_yk", 32'(yk), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_div_zero", 32'(div_zero), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(18'h04000, 18'h02000, mk(18'h04000, 1'b0, 1'b0));
        wait_done(1'b1);
        // Following ops start in the done cycle, exercising back-to-back acceptance.
        issue(18'h03000, 18'h06000, mk(18'h01000, 1'b0, 1'b0));
        wait_done(1'b0);
        issue(18'h02000, 18'h06000, mk(18'h00AAA, 1'b0, 1'b0));
        wait_done(1'b0);
        issue(18'h3E000, 18'h04000, mk(18'h3F000, 1'b0, 1'b0));
        wait_done(1'b0);
        issue(18'h3E000, 18'h06000, mk(18'h3F556, 1'b0, 1'b0));
        wait_done(1'b0);
        issue(18'h1E000, 18'h00800, mk(18'h1FFFF, 1'b1, 1'b0));
        wait_done(1'b0);
        issue(18'h20000, 18'h02000, mk(18'h20000, 1'b0, 1'b0));
        wait_done(1'b0);
        issue(18'h02000, 18'h00000, mk(18'h1FFFF, 1'b0, 1'b1));
        wait_done(1'b1);
        issue(18'h00000, 18'h00000, mk(18'h00000, 1'b0, 1'b1));
        wait_done(1'b0);

        // A second start while busy must be ignored.
        issue(18'h04000, 18'h02000, mk(18'h04000, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        start = 1'b1;
        ykgain = 18'h06000;
        gain_set = 18'h02000;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);

        // Reset mid-operation aborts without a done pulse.
        issue(18'h1E000, 18'h02000, mk(18'h1E000, 1'b0, 1'b0));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_yk", 32'(yk), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(18'h3E000, 18'h3C000, mk(18'h01000, 1'b0, 1'b0));
        wait_done(1'b0);

        for (int i = 0; i < 30; i++) begin
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            issue(a, b, model(a, b));
            wait_done(1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
